// File: rtl/knn_result_reader_pkg.sv
// -----------------------------------------------------------------------------
// knn_result_reader_pkg
//   Shared definitions for the k-NN result reader:
//     - state_t      : controller FSM state encoding
//     - LABEL_LSB/W  : position and width of the class label in the info word
//     - KNN_ID_W     : width of the neighbor index driven on knn_id
//     - VOTES_W/MAX  : width and saturation value of the reported vote count
//     - cnt_width()  : counter width able to hold the value n
// -----------------------------------------------------------------------------
package knn_result_reader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CAPT = 3'd2,
        VOTE = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam int LABEL_LSB = 0;
    localparam int LABEL_W   = 4;
    localparam int KNN_ID_W  = 4;
    localparam int VOTES_W   = 4;
    localparam int VOTES_MAX = 15;

    // Bits needed to count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/knn_vote_hist.sv
// -----------------------------------------------------------------------------
// knn_vote_hist
//   Per-class vote histogram plus a sequential argmax scan.
//   Optional feature macro: KNN_TIEBREAK_NEAREST_EN
//     undefined : equal counts keep the earlier (lowest) label
//     defined   : equal counts go to the label of the nearest neighbor
//
//   Ports
//     clk, rst    : clock, asynchronous active-low reset
//     clear       : zero all counters, the scan pointer and the best result
//     inc_en      : add one vote for inc_label (labels >= NBR_CLASS dropped)
//     inc_label   : class label of the neighbor being captured
//     near_we     : (macro only) remember inc_label as the nearest label
//     scan_en     : examine one class this cycle, ascending from 0
//     scan_last   : the class examined this cycle is the last one
//     best_label  : winning label so far
//     best_count  : vote count of the winning label
// -----------------------------------------------------------------------------
module knn_vote_hist
    import knn_result_reader_pkg::*;
#(
    parameter int NBR_CLASS = 4,
    parameter int CNT_W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               inc_en,
    input  logic [LABEL_W-1:0] inc_label,
`ifdef KNN_TIEBREAK_NEAREST_EN
    input  logic               near_we,
`endif
    input  logic               scan_en,
    output logic               scan_last,
    output logic [LABEL_W-1:0] best_label,
    output logic [CNT_W-1:0]   best_count
);

    logic [CNT_W-1:0]   hist_q [NBR_CLASS];
    logic [LABEL_W-1:0] cls_q;
    logic [LABEL_W-1:0] best_label_q;
    logic [CNT_W-1:0]   best_count_q;
    logic [CNT_W-1:0]   cur_count;
    logic               take;
`ifdef KNN_TIEBREAK_NEAREST_EN
    logic [LABEL_W-1:0] near_label_q;
`endif

    // Count of the class currently under the scan pointer.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        cur_count = '0;
        for (int c = 0; c < NBR_CLASS; c++) begin
            if (cls_q == LABEL_W'(c)) begin
                cur_count = hist_q[c];
            end
        end
    end

    // Strictly greater replaces the best, so ties stay with the earlier label
    // unless the nearest-neighbor rule claims them.
`ifdef KNN_TIEBREAK_NEAREST_EN
    assign take = (cur_count > best_count_q) ||
                  ((cur_count == best_count_q) && (cls_q == near_label_q));
`else
    assign take = (cur_count > best_count_q);
`endif

    assign scan_last  = (cls_q == LABEL_W'(NBR_CLASS - 1));
    assign best_label = best_label_q;
    assign best_count = best_count_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the counter array is small and must read as zero after
            // reset, so it is reset like any other register rather than
            // treated as uninitialised storage.
            for (int c = 0; c < NBR_CLASS; c++) begin
                hist_q[c] <= '0;
            end
            cls_q        <= '0;
            best_label_q <= '0;
            best_count_q <= '0;
`ifdef KNN_TIEBREAK_NEAREST_EN
            near_label_q <= '0;
`endif
        end else if (clear) begin
            for (int c = 0; c < NBR_CLASS; c++) begin
                hist_q[c] <= '0;
            end
            cls_q        <= '0;
            best_label_q <= '0;
            best_count_q <= '0;
`ifdef KNN_TIEBREAK_NEAREST_EN
            near_label_q <= '0;
`endif
        end else begin
            // Out-of-range labels match no counter and are simply dropped.
            if (inc_en) begin
                for (int c = 0; c < NBR_CLASS; c++) begin
                    if (inc_label == LABEL_W'(c)) begin
                        hist_q[c] <= hist_q[c] + CNT_W'(1);
                    end
                end
            end
`ifdef KNN_TIEBREAK_NEAREST_EN
            // A discarded nearest label never matches a scanned class.
            if (near_we) begin
                near_label_q <= inc_label;
            end
`endif
            if (scan_en) begin
                if (take) begin
                    best_label_q <= cls_q;
                    best_count_q <= cur_count;
                end
                cls_q <= cls_q + LABEL_W'(1);
            end
        end
    end

endmodule

// File: rtl/knn_result_reader.sv
// -----------------------------------------------------------------------------
// knn_result_reader
//   Reads NBR_KNN neighbor entries (nearest first), votes on their class
//   labels and presents the majority class with a valid/ready handshake.
//   Optional feature macro: KNN_TIEBREAK_NEAREST_EN (ties go to the label of
//   neighbor 0 instead of the lowest label; latency is unchanged).
//
//   Ports
//     clk          : clock
//     rst          : asynchronous active-low reset
//     start        : one-cycle pulse, begins a classification when idle
//     busy         : controller is not idle
//     knn_get      : read strobe to the neighbor list
//     knn_id       : neighbor index being read (0 = nearest)
//     knn_info     : neighbor info word, valid the cycle after knn_get;
//                    bits [3:0] hold the class label
//     class_valid  : result available
//     class_ready  : consumer accepts the result
//     class_out    : winning class label
//     class_votes  : vote count of the winner, saturated at 15
//
//   Timing: start sampled at edge 0 gives knn_get in cycle 1 and class_valid
//   in cycle 2*NBR_KNN + NBR_CLASS + 1.
// -----------------------------------------------------------------------------
module knn_result_reader
    import knn_result_reader_pkg::*;
#(
    parameter int NBR_KNN   = 4,
    parameter int NBR_CLASS = 4,
    parameter int INFO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              knn_get,
    output logic [3:0]        knn_id,
    input  logic [INFO_W-1:0] knn_info,
    output logic              class_valid,
    input  logic              class_ready,
    output logic [3:0]        class_out,
    output logic [3:0]        class_votes
);

    localparam int CNT_W = cnt_width(NBR_KNN);
    localparam int EXT_W = (CNT_W > VOTES_W) ? CNT_W : VOTES_W;

    state_t              state_q, state_d;
    logic [KNN_ID_W-1:0] idx_q, idx_d;
    logic                hist_clear;
    logic                inc_en;
    logic                scan_en;
    logic                scan_last;
    logic [LABEL_W-1:0]  label;
    logic [LABEL_W-1:0]  best_label;
    logic [CNT_W-1:0]    best_count;
    logic [EXT_W-1:0]    count_ext;
    logic [VOTES_W-1:0]  votes_sat;
    logic                unused_info_parity;

    assign label = knn_info[LABEL_LSB +: LABEL_W];
    // Bits above the label carry no meaning for classification.
    assign unused_info_parity = ^knn_info;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hist_clear = 1'b0;
        inc_en     = 1'b0;
        scan_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    hist_clear = 1'b1;
                    idx_d      = '0;
                    state_d    = READ;
                end
            end
            READ: begin
                state_d = CAPT;
            end
            CAPT: begin
                // knn_info answers the READ of the previous cycle.
                inc_en = 1'b1;
                if (idx_q == KNN_ID_W'(NBR_KNN - 1)) begin
                    state_d = VOTE;
                end else begin
                    idx_d   = idx_q + KNN_ID_W'(1);
                    state_d = READ;
                end
            end
            VOTE: begin
                scan_en = 1'b1;
                if (scan_last) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (class_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- histogram
    knn_vote_hist #(
        .NBR_CLASS (NBR_CLASS),
        .CNT_W     (CNT_W)
    ) u_hist (
        .clk        (clk),
        .rst        (rst),
        .clear      (hist_clear),
        .inc_en     (inc_en),
        .inc_label  (label),
`ifdef KNN_TIEBREAK_NEAREST_EN
        .near_we    (inc_en && (idx_q == '0)),
`endif
        .scan_en    (scan_en),
        .scan_last  (scan_last),
        .best_label (best_label),
        .best_count (best_count)
    );

    // ------------------------------------------------------------ outputs
    // The winner registers do not move in OUT, so the result is stable for
    // as long as the consumer stalls.
    assign count_ext = EXT_W'(best_count);
    assign votes_sat = (count_ext > EXT_W'(VOTES_MAX)) ? VOTES_W'(VOTES_MAX)
                                                       : count_ext[VOTES_W-1:0];

    assign busy        = (state_q != IDLE);
    assign knn_get     = (state_q == READ);
    assign knn_id      = knn_get ? idx_q : '0;
    assign class_valid = (state_q == OUT);
    assign class_out   = class_valid ? best_label : '0;
    assign class_votes = class_valid ? votes_sat : '0;

endmodule

// File: doc/knn_result_reader.md
KNN_RESULT_READER -- requirements
Module: knn_result_reader

Interface
REQ-001 SHALL have parameter NBR_KNN, default 4: number of neighbor entries read per classification.
REQ-002 SHALL have parameter NBR_CLASS, default 4: number of class labels, with a maximum of 16.
REQ-003 SHALL have parameter INFO_W, default 8: width of the neighbor info word.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a classification.
REQ-007 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-008 SHALL have port knn_get, output, 1 bit: read strobe to the neighbor list.
REQ-009 SHALL have port knn_id, output, 4 bits: neighbor index being read (0 = nearest).
REQ-010 SHALL have port knn_info, input, INFO_W bits: neighbor info word; bits [3:0] = class label; the word is valid on the cycle after knn_get.
REQ-011 SHALL have port class_valid, output, 1 bit: classification result available.
REQ-012 SHALL have port class_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port class_out, output, 4 bits: winning class label.
REQ-014 SHALL have port class_votes, output, 4 bits: vote count of the winning class.

Function
REQ-015 FSM states SHALL be IDLE, READ, CAPT, VOTE and OUT.
REQ-016 IDLE: start=1 SHALL clear all histogram counters, set idx=0 and go to READ; start SHALL be ignored in every other state.
REQ-017 READ SHALL drive knn_get=1 and knn_id=idx for exactly one cycle, then go to CAPT; knn_get SHALL be 0 in all other states.
REQ-018 CAPT SHALL sample knn_info[3:0]:
- label < NBR_CLASS: increment hist[label];
- otherwise: discard.
REQ-019 From CAPT, idx == NBR_KNN-1 SHALL go to VOTE; otherwise idx++ and back to READ.
REQ-020 VOTE SHALL scan classes 0..NBR_CLASS-1, one per cycle, in ascending order, keeping the best (label, count).
REQ-021 In VOTE, a class SHALL replace the best only if its count is strictly greater, so ties go to the lowest label.
REQ-022 After NBR_CLASS scan cycles, VOTE SHALL go to OUT.
REQ-023 OUT SHALL assert class_valid and hold class_out/class_votes stable until class_ready=1 is sampled.
REQ-024 On the cycle class_valid=1 and class_ready=1, the FSM SHALL return to IDLE.
REQ-025 class_ready asserted outside OUT SHALL have no effect.
REQ-026 Latency: a start pulse sampled at edge 0 SHALL produce the first knn_get in cycle 1 and class_valid in cycle 2*NBR_KNN+NBR_CLASS+1 (13 with defaults).
REQ-027 If every label is discarded, the result SHALL be class_out=0 and class_votes=0.
REQ-028 Histogram counters SHALL be wide enough for NBR_KNN; class_votes SHALL saturate at 15.

Reset
REQ-029 rst=0 SHALL, asynchronously and from any state, force IDLE and set busy=0, knn_get=0, knn_id=0, class_valid=0, class_out=0, class_votes=0, idx=0, and all histogram counters to 0.
REQ-030 An operation interrupted by reset SHALL be abandoned; no partial result SHALL be emitted after reset release.

Configuration
REQ-031 Macro KNN_TIEBREAK_NEAREST_EN SHALL select the tie-break rule.
REQ-032 Without the macro, ties SHALL resolve to the lowest label (REQ-021).
REQ-033 With the macro defined:
- the label captured for idx=0 SHALL be stored;
- in VOTE, on an equal count, the stored label SHALL win;
- latency SHALL be unchanged.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the label field position/width constants (LABEL_LSB=0, LABEL_W=4) and the knn_id width.
REQ-035 A sub-module knn_vote_hist SHALL contain the histogram counters, the clear/increment logic and the sequential argmax scan.

Verification
REQ-036 Labels {2,2,1,3} for ids 0..3, start -> class_out=2, class_votes=2, class_valid rising in cycle 13.
REQ-037 Labels {3,1,1,3}, start -> class_out=1, class_votes=2; with KNN_TIEBREAK_NEAREST_EN -> class_out=3, class_votes=2.
REQ-038 Labels {7,9,15,12} (all >= NBR_CLASS) -> class_out=0, class_votes=0.
REQ-039 Backpressure and start filtering:
- class_ready held 0 for 5 cycles in OUT -> class_valid and class_out stay stable;
- a second start pulse during busy -> ignored;
- IDLE is entered one cycle after class_ready=1.
REQ-040 rst=0 asserted in the CAPT cycle for idx=2 -> all outputs at reset values immediately; a fresh start with labels {0,0,0,0} -> class_out=0, class_votes=4.
